// File: rtl/pipe_pkg.sv
// Shared definitions for processor stage registers: NOP word, default field
// widths and the stage-occupancy encoding (EMPTY/ONE/FULL).
package pipe_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int DATA_W_DEF  = 32;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Occupancy follows directly from the valid bits; skid is only ever valid behind main.
    function automatic occ_e occ_from_valid(input logic main_v, input logic skid_v);
        if (!main_v) begin
            return OCC_EMPTY;
        end
        if (skid_v) begin
            return OCC_FULL;
        end
        return OCC_ONE;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One stage-register entry: a valid bit plus a payload register, with
// asynchronous active-low reset, load (sets valid) and clear (wins over load).
module pipe_entry #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    logic         r_valid;
    logic [W-1:0] r_payload;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else begin
            if (clear) begin
                r_valid <= 1'b0;
            end else if (load) begin
                r_valid <= 1'b1;
            end
            if (load && !clear) begin
                r_payload <= d;
            end
        end
    end

    assign valid = r_valid;
    assign q     = r_payload;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register for PC, instruction and two operands.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with registered in_ready.
module pipe_stage_reg #(
    parameter int                 PC_W     = pipe_pkg::PC_W_DEF,
    parameter int                 INSTR_W  = pipe_pkg::INSTR_W_DEF,
    parameter int                 DATA_W   = pipe_pkg::DATA_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(pipe_pkg::NOP_WORD)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [DATA_W-1:0]  out_a,
    output logic [DATA_W-1:0]  out_b
);
    import pipe_pkg::*;

    localparam int PAY_W = PC_W + INSTR_W + 2 * DATA_W;

    logic [PAY_W-1:0]   w_in_payload;
    logic [PAY_W-1:0]   w_main_d;
    logic [PAY_W-1:0]   w_main_q;
    logic               w_main_valid;
    logic               w_main_load;
    logic               w_main_clear;
    logic               w_in_xfer;
    logic               w_out_xfer;
    occ_e               w_state;
    logic [PC_W-1:0]    w_q_pc;
    logic [INSTR_W-1:0] w_q_instr;
    logic [DATA_W-1:0]  w_q_a;
    logic [DATA_W-1:0]  w_q_b;

    assign w_in_payload = {in_pc, in_instr, in_a, in_b};
    assign w_in_xfer    = in_valid && in_ready;
    assign w_out_xfer   = w_main_valid && out_ready;

    pipe_entry #(.W(PAY_W)) u_main (
        .clock (clock),
        .reset (reset),
        .load  (w_main_load),
        .clear (w_main_clear),
        .d     (w_main_d),
        .valid (w_main_valid),
        .q     (w_main_q)
    );

`ifdef PIPE_STAGE_SKID_EN
    logic             w_skid_valid;
    logic [PAY_W-1:0] w_skid_q;
    logic             w_skid_load;
    logic             w_skid_clear;
    logic             w_main_from_skid;

    pipe_entry #(.W(PAY_W)) u_skid (
        .clock (clock),
        .reset (reset),
        .load  (w_skid_load),
        .clear (w_skid_clear),
        .d     (w_in_payload),
        .valid (w_skid_valid),
        .q     (w_skid_q)
    );

    assign w_state  = occ_from_valid(w_main_valid, w_skid_valid);
    assign in_ready = !w_skid_valid;
    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_payload;

    // Flush clears both entries and drops any beat presented in the same cycle.
    always_comb begin
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (w_state)
                OCC_EMPTY: w_main_load = w_in_xfer;
                OCC_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_load = 1'b1;
                    end else if (w_in_xfer) begin
                        w_skid_load = 1'b1;
                    end else if (w_out_xfer) begin
                        w_main_clear = 1'b1;
                    end
                end
                OCC_FULL: begin
                    if (w_out_xfer) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign w_state  = occ_from_valid(w_main_valid, 1'b0);
    assign in_ready = !w_main_valid || out_ready;
    assign w_main_d = w_in_payload;

    always_comb begin
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        if (flush) begin
            w_main_clear = 1'b1;
        end else begin
            case (w_state)
                OCC_EMPTY: w_main_load = w_in_xfer;
                OCC_ONE: begin
                    if (w_in_xfer) begin
                        w_main_load = 1'b1;
                    end else if (w_out_xfer) begin
                        w_main_clear = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

    assign {w_q_pc, w_q_instr, w_q_a, w_q_b} = w_main_q;

    // Empty stage presents a NOP so downstream decode never sees stale payload.
    always_comb begin
        out_valid = w_main_valid;
        out_pc    = '0;
        out_instr = NOP_WORD;
        out_a     = '0;
        out_b     = '0;
        if (w_main_valid) begin
            out_pc    = w_q_pc;
            out_instr = w_q_instr;
            out_a     = w_q_a;
            out_b     = w_q_b;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register carrying PC, instruction word and two operands between adjacent processor stages (decode→execute and later stage boundaries). It is the successor of the fixed 32-bit four-register stage latch. It adds a valid/ready handshake, a synchronous flush that inserts a bubble, and an optional two-entry skid buffer so upstream `in_ready` is registered. When the stage is empty, the outputs present a NOP instruction so downstream decode logic never sees stale data.

## Interface
- `PC_W`, 32, PC field width
- `INSTR_W`, 32, instruction field width
- `DATA_W`, 32, width of each operand field (A, B)
- `NOP_WORD`, `pipe_pkg::NOP_WORD` (32'h0000_0000), instruction value driven when the stage is empty
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous flush; discards all held entries
- `in_valid`  in  1  upstream beat present
- `in_ready`  out  1  stage can accept a beat
- `in_pc`, `in_instr`, `in_a`, `in_b`  in  PC_W/INSTR_W/DATA_W/DATA_W  upstream payload
- `out_valid`  out  1  downstream beat present
- `out_ready`  in  1  downstream accepts
- `out_pc`, `out_instr`, `out_a`, `out_b`  out  PC_W/INSTR_W/DATA_W/DATA_W  downstream payload

## Operation
- Input transfer: `in_valid && in_ready` at a rising edge. Output transfer: `out_valid && out_ready` at a rising edge.
- Storage: main entry (drives outputs). With skid enabled, there is also a skid entry. Each entry holds a valid bit and the payload.
- Output mux:
  - `out_valid` = main valid.
  - When main is invalid: `out_pc`/`out_a`/`out_b` = 0 and `out_instr` = NOP_WORD.
  - When main is valid: outputs show the main payload.
- States (skid build), encoded by valid bits:
  - EMPTY (0 entries)
  - ONE (main only)
  - FULL (main + skid)
- State transitions:
  - EMPTY + input transfer → ONE.
  - ONE + input only → FULL (beat goes to skid).
  - ONE + output only → EMPTY.
  - ONE + input and output → ONE (new beat goes to main).
  - FULL + output transfer → ONE (skid moves to main). No input transfer is possible in FULL.
- Flush has priority over everything:
  - At the flush edge, all valid bits clear and any input beat presented that cycle is dropped.
  - An output transfer in the flush cycle still counts as completed by the consumer.
- Payload registers load only on accept. Payload of invalid entries is don't-care internally but masked at the outputs.
- Reset mid-operation: all entries are invalidated immediately (asynchronous), independent of `clock`.

## Timing
- Latency: a beat accepted at edge N appears on the outputs after edge N (one cycle). Throughput is 1 beat/cycle with `out_ready` held high.
- Skid build: `in_ready` = !skid_valid, a register output with no combinational path from `out_ready`.
- Non-skid build: `in_ready` = !main_valid || out_ready (combinational).
- Reset values: `out_valid`=0, `in_ready`=1, `out_pc`/`out_a`/`out_b`=0, `out_instr`=NOP_WORD.
- `in_ready` is 1 in the first cycle after flush.
- `out_valid` never drops without an output transfer, except on flush or reset.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Two-entry skid buffer, registered `in_ready`.
  - Full throughput under backpressure release.
- Undefined:
  - Single main entry; the skid entry and its logic are absent.
  - Combinational `in_ready` as above.
  - Same latency, same flush/reset/NOP behaviour.

## Structure
- `pipe_pkg`: `NOP_WORD` constant, default widths, and the stage-occupancy state encoding (EMPTY/ONE/FULL) shared with other stage registers.
- Sub-module `pipe_entry`: one valid bit plus payload register with async active-low reset, load and clear. Instantiated once (main), or twice when `PIPE_STAGE_SKID_EN` is defined.

## Test plan
- Reset asserted mid-stream with `out_valid`=1 → `out_valid`=0 and `out_instr`=NOP_WORD immediately, before the next edge; `in_ready`=1.
- Stream PCs 0x00, 0x04, 0x08 with `out_ready`=1 → outputs show 0x00, 0x04, 0x08 on consecutive cycles, each one cycle after accept.
- Skid: `out_ready`=0 with two beats (PC 0x10, 0x14) → `in_ready`=0 after the second accept. Raise `out_ready` → 0x10 then 0x14 emitted with no loss or duplication; `in_ready` returns to 1.
- Flush while FULL, with `in_valid`=1 carrying PC 0x20 → next cycle `out_valid`=0, `out_instr`=NOP_WORD, and 0x20 never appears.
- Simultaneous accept and emit in state ONE (main PC 0x30, input PC 0x34) → next cycle main shows 0x34, state stays ONE.
- Random valid/ready/flush run (10k cycles) against a queue model → in-order delivery, no drops except flushed beats; checked with and without `PIPE_STAGE_SKID_EN`.
